// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA raster timing path.
// Defaults describe 1280x1024 at 60 Hz with a 108 MHz pixel clock.
package vga_timing_gen_pkg;

    // Colour shown in the active area when the renderer does not own the pixel.
    localparam logic [23:0] COLOR_BACKGROUND = 24'h1A1A2E;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;

    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;

    // Pixel-aligned side signals. Sync bits are active-high here; polarity
    // is applied only in the output register.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register for pixel-aligned side signals.
// DEPTH=0 degenerates to a plain wire.
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stages [DEPTH];

            // Shift one stage per clock; reset loads every stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/DE decode and registered VGA output stage.
// Renderer data returns DRAW_LATENCY cycles after the coordinate; the decoded
// sync/DE are delayed by the same amount so the output register sees them aligned.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int PIX_WIDTH    = 12,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int DRAW_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PIX_WIDTH-1:0] pix_x_o,
    output logic [PIX_WIDTH-1:0] pix_y_o,
    output logic                 pix_active_o,
    output logic                 vblank_start_o,
    input  logic [23:0]          vga_data_i,
    input  logic                 vga_data_en_i,
    output logic [23:0]          vga_rgb_o,
    output logic                 vga_hs_o,
    output logic                 vga_vs_o,
    output logic                 vga_de_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [PIX_WIDTH-1:0] h_cnt;
    logic [PIX_WIDTH-1:0] v_cnt;
    logic                 h_last;
    logic                 v_last;
    sync_t                raw;
    sync_t                dly;
    logic [2:0]           raw_bits;
    logic [2:0]           dly_bits;

    assign h_last = (h_cnt == PIX_WIDTH'(H_TOTAL - 1));
    assign v_last = (v_cnt == PIX_WIDTH'(V_TOTAL - 1));

    // Free-running raster counters; v advances only on the h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Raw decodes straight from the counter registers.
    always_comb begin
        raw    = '0;
        raw.de = (h_cnt < PIX_WIDTH'(H_ACTIVE)) && (v_cnt < PIX_WIDTH'(V_ACTIVE));
        raw.hs = (h_cnt >= PIX_WIDTH'(HS_START)) && (h_cnt < PIX_WIDTH'(HS_END));
        raw.vs = (v_cnt >= PIX_WIDTH'(VS_START)) && (v_cnt < PIX_WIDTH'(VS_END));
    end

    assign pix_x_o        = h_cnt;
    assign pix_y_o        = v_cnt;
    assign pix_active_o   = raw.de;
    assign vblank_start_o = (h_cnt == '0) && (v_cnt == PIX_WIDTH'(V_ACTIVE));

    assign raw_bits = raw;

    pipe_delay #(
        .WIDTH     (3),
        .DEPTH     (DRAW_LATENCY),
        .RESET_VAL (3'b000)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_bits),
        .q     (dly_bits)
    );

    assign dly = sync_t'(dly_bits);

    // Output register: apply sync polarity and force black outside the active area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rgb_o <= 24'h0;
            vga_de_o  <= 1'b0;
            vga_hs_o  <= !HS_POL;
            vga_vs_o  <= !VS_POL;
        end else begin
            vga_de_o <= dly.de;
            vga_hs_o <= dly.hs ? HS_POL : !HS_POL;
            vga_vs_o <= dly.vs ? VS_POL : !VS_POL;
            if (dly.de) vga_rgb_o <= vga_data_en_i ? vga_data_i : COLOR_BACKGROUND;
            else        vga_rgb_o <= 24'h0;
        end
    end

endmodule
